uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  UART transmit side of the 2.5 MHz serial link. Serialises one 8-bit word per
//  frame onto TX: start(0), 8 data bits LSB first, stop(1), CLKS_PER_BIT clocks
//  per bit (default 5 -> 500 kbaud). A 1-deep holding register allows back-to-back
//  frames with no idle gap. Drives the line read by the link receiver.
// PARAMETERS
//  CLKS_PER_BIT  5  clocks per serial bit; legal range 2..63
//  DATA_BITS     8  data bits per frame; fixed at 8 in this revision
// PORTS
//  CLK    in   1  system clock, 2.5 MHz, all logic on posedge
//  RST    in   1  reset, asynchronous, active-high
//  data   in   8  word to send, [8:1]; data[1] is sent first
//  send   in   1  request; accepted on a posedge where send & ready
//  ready  out  1  1 = holding register empty, send will be accepted
//  busy   out  1  1 = a frame is on the line (start..stop)
//  done   out  1  one-cycle pulse on the last clock of each stop bit
//  TX     out  1  serial line, idle high
// BEHAVIOUR
//  - Reset (async, immediate): TX=1, busy=0, ready=1, done=0, state IDLE,
//    bit timer=0, bit index=0, holding register empty. Reset mid-frame aborts
//    the frame at once (TX forced high); held word discarded.
//  - Registers: shift reg, holding reg + valid flag, bit timer 0..CLKS_PER_BIT-1,
//    bit index 0..7. TX, busy, done, ready all registered.
//  - Accept: send & ready at posedge -> data copied to holding reg, ready=0 next
//    cycle. send while ready=0 is ignored, no error flag. data only sampled there.
//  - FSM: IDLE -> START -> DATA (x8) -> STOP -> IDLE or START.
//    IDLE: TX=1, busy=0. Holding valid -> load shift reg, clear holding
//      (ready=1), go START. Latency: TX falls on the 1st posedge after accept.
//    START: TX=0 for CLKS_PER_BIT clocks.
//    DATA: TX=shift[1] per bit, shift right each bit; index 0..7, exits at 7.
//    STOP: TX=1 for CLKS_PER_BIT clocks; last clock asserts done. Then holding
//      valid -> load and go START directly (next start bit immediately follows
//      stop bit, zero gap); else IDLE.
//  - Frame length exactly 10*CLKS_PER_BIT clocks (11* with parity).
//  - Simultaneous accept and holding->shift transfer on same edge: transfer
//    wins first, new word lands in now-empty holding; ready stays 1 in that
//    cycle only if nothing was accepted.
//  - busy=1 from first START clock through last STOP clock, continuous across
//    back-to-back frames. Timer wraps to 0 at each bit boundary; no overflow.
// CONFIGURATION
//  - UART_TX_PARITY_EN defined: PARITY state between DATA and STOP, TX = even
//    parity (XOR of the 8 data bits, computed at load), frame 11 bits.
//  - Undefined: no PARITY state, 10-bit frame, no parity logic synthesised.
//    Receiver interop is only required without the macro.
// TESTING
//  1. RST pulse mid-idle -> TX=1, ready=1, busy=0, done=0 asynchronously.
//  2. send 0x55 once -> TX: 0 x5, then 1,0,1,0,1,0,1,0 x5 each, 1 x5; done
//     pulse at clock 50 after TX fall; busy high 50 clocks.
//  3. send 0xA5 then 0x3C while busy -> ready low until 2nd frame starts; 2nd
//     start bit begins the clock after 1st stop ends; 100 busy clocks total.
//  4. 3rd send while ready=0 -> ignored; only 2 frames, 2 done pulses.
//  5. RST at clock 23 of a frame with word held -> TX=1 immediately; no
//     further frames, done never asserts.
//  6. Loopback into link receiver, send 0xC3 -> receiver OK=1, frame bits
//     [9:2]=0xC3. With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, 55 clocks.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, stop, with a 1-deep holding register for gapless frames.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 5,
  parameter int DATA_BITS    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [8:1] data,
  input  logic       send,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       TX
);

  localparam logic [5:0] LAST_TICK  = 6'(CLKS_PER_BIT - 1);
  localparam logic [5:0] DONE_TICK  = 6'(CLKS_PER_BIT - 2);
  localparam logic [2:0] LAST_INDEX = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t     state;
  logic [5:0] timer;
  logic [2:0] bit_index;
  logic [8:1] shift;
  logic [8:1] holding;
  logic       hold_valid;
`ifdef UART_TX_PARITY_EN
  logic       parity_bit;
`endif

  logic bit_end;
  logic accept;
  logic transfer;
  logic hold_next;

  // The holding register empties on a transfer before a same-edge accept refills it.
  assign bit_end   = (timer == LAST_TICK);
  assign accept    = send & ready;
  assign transfer  = hold_valid & ((state == IDLE) | ((state == STOP) & bit_end));
  assign hold_next = accept | (hold_valid & ~transfer);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      timer      <= 6'd0;
      bit_index  <= 3'd0;
      shift      <= 8'd0;
      holding    <= 8'd0;
      hold_valid <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      TX         <= 1'b1;
    end else begin
      if (accept) begin
        holding <= data;
      end
      hold_valid <= hold_next;
      ready      <= ~hold_next;
      done       <= (state == STOP) && (timer == DONE_TICK);

      case (state)
        IDLE: begin
          timer <= 6'd0;
          if (transfer) begin
            shift      <= holding;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^holding;
`endif
            state      <= START;
            TX         <= 1'b0;
            busy       <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            timer     <= 6'd0;
            bit_index <= 3'd0;
            TX        <= shift[1];
            shift     <= {1'b0, shift[8:2]};
            state     <= DATA;
          end else begin
            timer <= timer + 6'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            timer <= 6'd0;
            if (bit_index == LAST_INDEX) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              TX    <= parity_bit;
`else
              state <= STOP;
              TX    <= 1'b1;
`endif
            end else begin
              bit_index <= bit_index + 3'd1;
              TX        <= shift[1];
              shift     <= {1'b0, shift[8:2]};
            end
          end else begin
            timer <= timer + 6'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            timer <= 6'd0;
            state <= STOP;
            TX    <= 1'b1;
          end else begin
            timer <= timer + 6'd1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            timer <= 6'd0;
            // A held word starts its start bit right after this stop bit, keeping busy high.
            if (transfer) begin
              shift      <= holding;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^holding;
`endif
              state      <= START;
              TX         <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 6'd1;
          end
        end

        default: begin
          state <= IDLE;
          TX    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized self-checking bench for uart_transmitter against a bit-position model of the serial frame.
module tb_uart_transmitter;

  localparam int CPB = 5;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CPB;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b1;
  logic       send  = 1'b0;
  logic [7:0] data  = 8'd0;
  logic       ready;
  logic       busy;
  logic       done;
  logic       TX;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_words[$];
  logic       cap[0:511];

  uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .data  (data),
    .send  (send),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .TX    (TX)
  );

  always #5 CLK = ~CLK;

  // n counts clocks from the first start-bit clock (n=1) of the first queued word.
  function automatic logic model_tx(input int n);
    int idx;
    int frame;
    int bitpos;
    logic [7:0] w;
    if (n < 1) return 1'b1;
    idx   = n - 1;
    frame = idx / FRAME_CLKS;
    if (frame >= model_words.size()) return 1'b1;
    w      = model_words[frame];
    bitpos = (idx % FRAME_CLKS) / CPB;
    if (bitpos == 0) return 1'b0;
    if (bitpos <= 8) return w[bitpos-1];
`ifdef UART_TX_PARITY_EN
    if (bitpos == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  function automatic logic model_busy(input int n);
    return (n >= 1) && (((n - 1) / FRAME_CLKS) < model_words.size());
  endfunction

  function automatic logic model_done(input int n);
    return model_busy(n) && (((n - 1) % FRAME_CLKS) == FRAME_CLKS - 1);
  endfunction

  task automatic run_frames(input string name, input int rst_at);
    int   window;
    int   dones;
    int   exp_dones;
    bit   aborted;
    logic e_tx;
    logic e_busy;
    logic e_done;
    logic e_ready;
    window  = model_words.size() * FRAME_CLKS + 6;
    dones   = 0;
    aborted = 0;
    @(negedge CLK);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s ready_before_send got=%b exp=1", name, ready);
    end
    data = model_words[0];
    send = 1'b1;
    @(negedge CLK);
    send = 1'b0;
    data = 8'($urandom);
    checks++;
    if (TX !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s tx_after_accept got=%b exp=1", name, TX);
    end
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s ready_after_accept got=%b exp=0", name, ready);
    end
    for (int n = 1; n <= window; n++) begin
      @(negedge CLK);
      cap[n] = TX;
      if (aborted) begin
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      end else begin
        e_tx    = model_tx(n);
        e_busy  = model_busy(n);
        e_done  = model_done(n);
        e_ready = (model_words.size() < 2) ? 1'b1 : ((n == 1) || (n > FRAME_CLKS));
      end
      checks++;
      if (TX !== e_tx) begin
        failures++;
        $display("[TB] FAIL %s tx n=%0d got=%b exp=%b", name, n, TX, e_tx);
      end
      checks++;
      if (busy !== e_busy) begin
        failures++;
        $display("[TB] FAIL %s busy n=%0d got=%b exp=%b", name, n, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        failures++;
        $display("[TB] FAIL %s done n=%0d got=%b exp=%b", name, n, done, e_done);
      end
      checks++;
      if (ready !== e_ready) begin
        failures++;
        $display("[TB] FAIL %s ready n=%0d got=%b exp=%b", name, n, ready, e_ready);
      end
      if (done === 1'b1) dones++;
      send = 1'b0;
      if (aborted) RST = 1'b0;
      if (n == 1 && model_words.size() > 1) begin
        data = model_words[1];
        send = 1'b1;
      end
      // A send while the holding register is full must be dropped.
      if (n == 4 && model_words.size() > 1) begin
        data = 8'($urandom);
        send = 1'b1;
      end
      if (n == rst_at) begin
        #2 RST = 1'b1;
        #1;
        checks++;
        if (TX !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
          failures++;
          $display("[TB] FAIL %s async_reset tx=%b busy=%b ready=%b done=%b exp tx=1 busy=0 ready=1 done=0",
                   name, TX, busy, ready, done);
        end
        aborted = 1;
      end
    end
    send = 1'b0;
    exp_dones = aborted ? 0 : model_words.size();
    checks++;
    if (dones !== exp_dones) begin
      failures++;
      $display("[TB] FAIL %s done_count got=%0d exp=%0d", name, dones, exp_dones);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #12;
    checks++;
    if (TX !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold tx=%b busy=%b ready=%b done=%b exp tx=1 busy=0 ready=1 done=0",
               TX, busy, ready, done);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (TX !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset tx=%b busy=%b ready=%b done=%b exp tx=1 busy=0 ready=1 done=0",
               TX, busy, ready, done);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (TX !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_reset_pulse tx=%b busy=%b ready=%b done=%b exp tx=1 busy=0 ready=1 done=0",
               TX, busy, ready, done);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_single();
    model_words = '{8'h55};
    run_frames("single_55", 0);
    for (int i = 0; i < 3; i++) begin
      model_words = '{8'($urandom)};
      run_frames("single_rand", 0);
    end
  endtask

  task automatic test_back_to_back();
    model_words = '{8'hA5, 8'h3C};
    run_frames("b2b_a5_3c", 0);
    for (int i = 0; i < 2; i++) begin
      model_words = '{8'($urandom), 8'($urandom)};
      run_frames("b2b_rand", 0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w0;
    w0 = 8'($urandom) & 8'hF7;
    model_words = '{w0, 8'($urandom)};
    run_frames("rst_mid_frame", 23);
    repeat (2) @(negedge CLK);
    checks++;
    if (RST !== 1'b0 || TX !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid_frame_tail rst=%b tx=%b busy=%b exp rst=0 tx=1 busy=0", RST, TX, busy);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] rx_data;
    logic       s;
    model_words = '{8'hC3};
    run_frames("loopback_c3", 0);
    rx_data = 8'd0;
    for (int b = 1; b <= 8; b++) begin
      s = cap[1 + b * CPB + CPB / 2];
      rx_data[b-1] = s;
    end
    checks++;
    if (cap[1 + CPB / 2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL loopback_start got=%b exp=0", cap[1 + CPB / 2]);
    end
    checks++;
    if (rx_data !== 8'hC3) begin
      failures++;
      $display("[TB] FAIL loopback_data got=%h exp=c3", rx_data);
    end
    checks++;
    if (cap[1 + (FRAME_BITS - 1) * CPB + CPB / 2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL loopback_stop got=%b exp=1", cap[1 + (FRAME_BITS - 1) * CPB + CPB / 2]);
    end
`ifdef UART_TX_PARITY_EN
    model_words = '{8'h07};
    run_frames("parity_07", 0);
    checks++;
    if (cap[1 + 9 * CPB + CPB / 2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL parity_bit got=%b exp=1", cap[1 + 9 * CPB + CPB / 2]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
